// File: rtl/pnm_max_pool_engine_if.sv
// Memory-side bus of the PNM max-pool engine: a read request/response port and a write strobe port.
// The engine drives the master modport; the PIM memory (or a model of it) drives the slave modport.
interface pnm_max_pool_engine_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int Address_Size = 16
);
  logic                          mem_rd_req;
  logic [Address_Size-1:0]       mem_rd_addr;
  logic                          mem_rd_valid;
  logic signed [DATA_WIDTH-1:0]  mem_rd_data;
  logic                          mem_wr_en;
  logic [Address_Size-1:0]       mem_wr_addr;
  logic signed [DATA_WIDTH-1:0]  mem_wr_data;

  modport master (
    output mem_rd_req, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/pnm_max_pool_engine.sv
// PNM max-pool engine: streams words start..end, writes one signed max per POOL_SIZE group.
// Optional macro PNM_MAXPOOL_RELU_FUSE_EN clamps negative group maxima to zero on write.
module pnm_max_pool_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int Address_Size = 16,
  parameter int POOL_SIZE    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    en,
  input  logic [Address_Size-1:0] start_addr,
  input  logic [Address_Size-1:0] end_addr,
  input  logic [Address_Size-1:0] result_addr,
  output logic                    busy,
  output logic                    done,
  pnm_max_pool_engine_if.master   mem
);

  localparam int                 CNT_W    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(POOL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EN,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [Address_Size-1:0]  src_q, src_d;
  logic [Address_Size-1:0]  end_q, end_d;
  logic [Address_Size-1:0]  res_q, res_d;
  logic [Address_Size-1:0]  grp_q, grp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic                     last_q, last_d;
  logic                     empty_q, empty_d;
  logic                     hold_q, hold_d;
  logic                     rd_req, wr_en;

  function automatic logic signed [DATA_WIDTH-1:0] pool_out(input logic signed [DATA_WIDTH-1:0] v);
`ifdef PNM_MAXPOOL_RELU_FUSE_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      end_q   <= '0;
      res_q   <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      end_q   <= end_d;
      res_q   <= res_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      last_q  <= last_d;
      empty_q <= empty_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    end_d   = end_q;
    res_d   = res_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    last_d  = last_q;
    empty_d = empty_q;
    hold_d  = 1'b0;
    rd_req  = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      // hold_q blocks a start arriving in the very cycle done rises
      S_IDLE: begin
        if (start && !hold_q) begin
          src_d   = start_addr;
          end_d   = end_addr;
          res_d   = result_addr;
          grp_d   = '0;
          cnt_d   = '0;
          max_d   = '0;
          last_d  = 1'b0;
          empty_d = (end_addr < start_addr);
          state_d = S_WAIT_EN;
        end
      end
      S_WAIT_EN: begin
        if (empty_q) begin
          state_d = S_FIN;
        end else if (en) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!en) begin
          state_d = S_WAIT_EN;
        end else begin
          rd_req  = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      // Ties keep the earlier element: only a strictly greater value replaces the max
      S_RD_WAIT: begin
        if (mem.mem_rd_valid) begin
          if ((cnt_q == '0) || (mem.mem_rd_data > max_q)) begin
            max_d = mem.mem_rd_data;
          end
          src_d  = src_q + 1'b1;
          last_d = (src_q == end_q);
          if ((src_q == end_q) || (cnt_q == CNT_LAST)) begin
            cnt_d   = '0;
            state_d = S_WR;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR: begin
        wr_en   = 1'b1;
        grp_d   = grp_q + 1'b1;
        state_d = last_q ? S_FIN : S_RD_REQ;
      end
      S_FIN: begin
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_IDLE);

  assign mem.mem_rd_req  = rd_req;
  assign mem.mem_rd_addr = rd_req ? src_q : '0;
  assign mem.mem_wr_en   = wr_en;
  assign mem.mem_wr_addr = wr_en ? (res_q + grp_q) : '0;
  assign mem.mem_wr_data = wr_en ? pool_out(max_q) : '0;

endmodule

// File: tb/tb_pnm_max_pool_engine.sv
// Directed, table-driven bench for pnm_max_pool_engine with a variable-latency memory model.
module tb_pnm_max_pool_engine;
  localparam int DW = 32;
  localparam int AW = 16;
`ifdef PNM_MAXPOOL_RELU_FUSE_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          en;
  logic [AW-1:0] start_addr, end_addr, result_addr;
  logic          busy, done;

  always #5 clk = ~clk;

  pnm_max_pool_engine_if #(.DATA_WIDTH(DW), .Address_Size(AW)) bus();

  pnm_max_pool_engine #(.DATA_WIDTH(DW), .Address_Size(AW), .POOL_SIZE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .en          (en),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .result_addr (result_addr),
    .busy        (busy),
    .done        (done),
    .mem         (bus)
  );

  typedef struct packed {
    logic [15:0] sa, ea, ra;
    logic [7:0]  lat, pause_at, poke_at, nr, nw;
    logic [15:0] wa0, wa1;
    logic [31:0] wd0, wd1;
  } vec_t;

  vec_t vt [7];
  int   dt [7][8];

  logic [31:0] mem [0:65535];
  int          lat;
  int          rd_cnt, wr_cnt, rd_viol, wr_viol, rd_addr_err;
  logic [15:0] exp_rd_addr;
  logic [15:0] wq_a [$];
  logic [31:0] wq_d [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expo(input int v);
    return (RELU && v < 0) ? 32'd0 : 32'(v);
  endfunction

  function automatic vec_t mk(input logic [15:0] sa, ea, ra, input int l, pa, po, nr, nw,
                              input logic [15:0] wa0, wa1, input int wd0, wd1);
    vec_t v;
    v.sa = sa; v.ea = ea; v.ra = ra;
    v.lat = 8'(l); v.pause_at = 8'(pa); v.poke_at = 8'(po);
    v.nr = 8'(nr); v.nw = 8'(nw);
    v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = expo(wd0); v.wd1 = expo(wd1);
    return v;
  endfunction

  // Memory read responder: answers each request after 'lat' cycles
  initial begin
    logic [15:0] a;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_req === 1'b1) begin
        a = bus.mem_rd_addr;
        rd_cnt++;
        if (a !== exp_rd_addr) rd_addr_err++;
        exp_rd_addr = a + 16'd1;
        if (en !== 1'b1) rd_viol++;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem[a];
        @(posedge clk);
        #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_wr_en === 1'b1) begin
        wr_cnt++;
        wq_a.push_back(bus.mem_wr_addr);
        wq_d.push_back(bus.mem_wr_data);
        if (bus.mem_rd_req !== 1'b0) wr_viol++;
      end
    end
  end

  task automatic load_mem(input int k);
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = vt[k].sa + 16'(i);
      mem[a] = 32'(dt[k][i]);
    end
  endtask

  task automatic clear_mon(input logic [15:0] sa);
    rd_cnt = 0; wr_cnt = 0; rd_viol = 0; wr_viol = 0; rd_addr_err = 0;
    exp_rd_addr = sa;
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic set_addrs(input int k);
    start_addr  = vt[k].sa;
    end_addr    = vt[k].ea;
    result_addr = vt[k].ra;
  endtask

  task automatic wait_done(input int k, output int c);
    bit paused, poked;
    c = 0; paused = 0; poked = 0;
    while (!done && c < 5000) begin
      @(posedge clk); #1;
      c++;
      if (vt[k].pause_at != 0 && !paused && rd_cnt == int'(vt[k].pause_at)) begin
        en = 1'b0;
        repeat (5) begin @(posedge clk); #1; c++; end
        en = 1'b1;
        paused = 1;
      end
      if (vt[k].poke_at != 0 && !poked && rd_cnt == int'(vt[k].poke_at)) begin
        start_addr = 16'h0000; end_addr = 16'h0001; result_addr = 16'h0500;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c++;
        poked = 1;
      end
    end
    check($sformatf("v%0d_done_within_bound", k), done, 1'b1);
  endtask

  task automatic check_results(input int k, input int c);
    check($sformatf("v%0d_reads", k), rd_cnt, vt[k].nr);
    check($sformatf("v%0d_writes", k), wr_cnt, vt[k].nw);
    check($sformatf("v%0d_rd_addr_seq_errs", k), rd_addr_err, 0);
    check($sformatf("v%0d_rd_while_en_low_or_wr", k), rd_viol, 0);
    check($sformatf("v%0d_wr_with_rd", k), wr_viol, 0);
    for (int i = 0; i < int'(vt[k].nw); i++) begin
      if (i < wq_a.size()) begin
        check($sformatf("v%0d_wr%0d_addr", k, i), wq_a[i], (i == 0) ? vt[k].wa0 : vt[k].wa1);
        check($sformatf("v%0d_wr%0d_data", k, i), wq_d[i], (i == 0) ? vt[k].wd0 : vt[k].wd1);
      end
    end
    check($sformatf("v%0d_busy_end", k), busy, 1'b0);
    if (k == 3) check("v3_done_low_cycles", c, 2);
  endtask

  task automatic run_vec(input int k);
    @(posedge clk); #1;
    load_mem(k);
    clear_mon(vt[k].sa);
    lat = int'(vt[k].lat);
    set_addrs(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_done_low_after_start", k), done, 1'b0);
    check($sformatf("v%0d_busy_after_start", k), busy, 1'b1);
    wait_done(k, cyc);
    check_results(k, cyc);
  endtask

  initial begin
    vt[0] = mk(16'h0100, 16'h0107, 16'h0200, 1, 0, 0, 8, 2, 16'h0200, 16'h0201, 7, -1);
    vt[1] = mk(16'h0010, 16'h0015, 16'h0200, 1, 0, 0, 6, 2, 16'h0200, 16'h0201, 4, -3);
    vt[2] = mk(16'h0100, 16'h0107, 16'h0200, 3, 3, 0, 8, 2, 16'h0200, 16'h0201, 7, -1);
    vt[3] = mk(16'h0009, 16'h0005, 16'h0200, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    vt[4] = mk(16'h0300, 16'h0303, 16'h0400, 2, 0, 0, 4, 1, 16'h0400, 16'h0000, -1, 0);
    vt[5] = mk(16'h0020, 16'h0024, 16'hFFFF, 2, 0, 0, 5, 2, 16'hFFFF, 16'h0000, 50, -2147483647 - 1);
    vt[6] = mk(16'h0100, 16'h0107, 16'h0200, 2, 0, 2, 8, 2, 16'h0200, 16'h0201, 7, -1);
    dt = '{'{1, -5, 7, 3, -2, -9, -1, -4},
           '{4, 4, 4, 4, -8, -3, 0, 0},
           '{1, -5, 7, 3, -2, -9, -1, -4},
           '{0, 0, 0, 0, 0, 0, 0, 0},
           '{-3, -7, -1, -2, 0, 0, 0, 0},
           '{-100, 50, 50, -7, -2147483647 - 1, 0, 0, 0},
           '{1, -5, 7, 3, -2, -9, -1, -4}};

    rst_n = 1'b0; start = 1'b0; en = 1'b1; lat = 1;
    start_addr = '0; end_addr = '0; result_addr = '0;
    clear_mon(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_req", bus.mem_rd_req, 1'b0);
    check("rst_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_rd_addr", bus.mem_rd_addr, 16'h0);
    check("rst_wr_addr", bus.mem_wr_addr, 16'h0);
    check("rst_wr_data", bus.mem_wr_data, 32'h0);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // start in the cycle done rises is ignored, accepted one cycle later
    run_vec(3);
    load_mem(0);
    clear_mon(vt[0].sa);
    lat = 1;
    set_addrs(0);
    start = 1'b1;
    @(posedge clk); #1;
    check("start_on_done_rise_ignored", done, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_next_cycle_accepted", done, 1'b0);
    wait_done(0, cyc);
    check_results(0, cyc);

    // asynchronous reset while a read is outstanding
    @(posedge clk); #1;
    load_mem(0);
    clear_mon(vt[0].sa);
    lat = 4;
    set_addrs(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (rd_cnt < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_test_reached_2nd_read", rd_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_done", done, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_rd_req", bus.mem_rd_req, 1'b0);
    check("async_rst_wr_en", bus.mem_wr_en, 1'b0);
    check("async_rst_rd_addr", bus.mem_rd_addr, 16'h0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_write", wr_cnt, 0);
    check("rst_no_more_reads", rd_cnt, 2);
    rst_n = 1'b1;
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pnm_max_pool_engine.md
Name: pnm_max_pool_engine

Overview:
PNM pooling datapath directly downstream of the PNM controller. It consumes the controller's Max_Pool_Start, Max_Pool_En and latched Start/End/Result addresses, and streams words from the PIM memory port. For each group of POOL_SIZE consecutive elements it writes one signed-max result to the result region. Its level-style done output feeds the controller's done_Max_Pool input.

Parameters:
DATA_WIDTH, 32, element/word width (two's-complement signed)
Address_Size, 16, word address width
POOL_SIZE, 4, elements per pooling group (2x2 window flattened); power of two, >=2

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle command pulse (Max_Pool_Start)
en  input  1  level enable (Max_Pool_En); work advances only while high
start_addr  input  Address_Size  first source word
end_addr  input  Address_Size  last source word (inclusive)
result_addr  input  Address_Size  first destination word
mem_rd_req  output  1  one-cycle read request
mem_rd_addr  output  Address_Size  read address, valid with mem_rd_req
mem_rd_valid  input  1  read data valid strobe
mem_rd_data  input  DATA_WIDTH  read data
mem_wr_en  output  1  one-cycle write strobe
mem_wr_addr  output  Address_Size  write address
mem_wr_data  output  DATA_WIDTH  write data
busy  output  1  high from command accept until done rises
done  output  1  high when idle/finished, low while a command is in flight

Behaviour:
- Reset (async assert, sync release): state IDLE; done=1; busy, mem_rd_req and mem_wr_en =0; address/data outputs 0; internal latches cleared. Reset mid-operation aborts immediately, and no further requests issue.
- States: IDLE, WAIT_EN, RD_REQ, RD_WAIT, WR, FIN.
- IDLE: start=1 latches the three addresses; next cycle busy=1, done=0, state WAIT_EN. start is ignored in every other state, with no relatch.
- end_addr < start_addr: accept, go to FIN, and make no memory accesses.
- WAIT_EN: remain while en=0; otherwise RD_REQ. en=0 in any state except RD_WAIT/WR returns to WAIT_EN with position kept (pause). An outstanding read always completes.
- RD_REQ: mem_rd_req=1 for exactly one cycle, with mem_rd_addr = current source pointer; then RD_WAIT.
- RD_WAIT: hold until mem_rd_valid (latency >=1, unbounded). The first element of a group loads the max register. Later elements replace it if signed mem_rd_data > max (ties keep the earlier value). The pointer then increments.
- Group boundary: after POOL_SIZE elements, or after the element at end_addr, go to WR. Otherwise go to RD_REQ.
- WR: mem_wr_en=1 for one cycle, mem_wr_addr = result_addr + group_index, mem_wr_data = max. group_index then increments. If the element at end_addr has been consumed, go to FIN; else go to RD_REQ.
- Partial trailing group (N = end-start+1 not a multiple of POOL_SIZE) is pooled over its remaining elements and writes one result. Results written = ceil(N/POOL_SIZE).
- Address arithmetic is modulo 2^Address_Size; wrap is not flagged.
- FIN: one cycle; then busy=0, done=1, state IDLE. A start in the same cycle done rises is ignored; it is accepted from the next cycle.
- mem_rd_req and mem_wr_en are never high in the same cycle.

Optional Feature:
PNM_MAXPOOL_RELU_FUSE_EN. When defined, mem_wr_data is clamped to 0 if the group max is negative, giving fused pool+ReLU. When undefined, the raw signed max is written. Timing is identical either way.

Test Plan:
- 8 elements, start=0x0100, end=0x0107, result=0x0200, data {1,-5,7,3, -2,-9,-1,-4}, en=1, rd latency 1 -> writes 0x0200=7 and 0x0201=-1; done low during the run, high after FIN; exactly 8 reads and 2 writes.
- 6 elements 0x0010..0x0015, data {4,4,4,4,-8,-3} -> 0x0200=4 (tie) and 0x0201=-3; 2 writes total.
- Same as the first case with en dropped for 5 cycles after the 3rd read and read latency 3 -> identical writes, no requests issued while en=0, only completion delayed.
- start with end=0x0005 and start=0x0009 -> no reads/writes; done low exactly 2 cycles, then high.
- rst_n asserted while in RD_WAIT -> outputs return to reset values asynchronously; no write occurs; a new start after release runs cleanly.
- Macro defined, group {-3,-7,-1,-2} -> writes 0; macro undefined -> writes -1.
